// File: rtl/irq_ctl.sv
// Programmable interrupt controller: latches source edges, masks and prioritises them, and
// drives the core's irq/iack handshake; registers are reached over the coprocessor bus.
module irq_ctl #(
    parameter int unsigned N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter logic [3:0]  SW_CODE   = 4'd10,
    parameter logic [3:0]  LW_CODE   = 4'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_i,
    input  logic [31:0]      cop_addr_i,
    input  logic [31:0]      cop_data_i,
    input  logic [3:0]       cop_mem_ctl_i,
    output logic [31:0]      cop_dout_o,
    output logic             irq_o,
    output logic [31:0]      irq_addr_o,
    input  logic             iack_i
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    localparam logic [2:0] R_STATUS = 3'd0;
    localparam logic [2:0] R_PEND   = 3'd1;
    localparam logic [2:0] R_MASK   = 3'd2;
    localparam logic [2:0] R_CTRL   = 3'd3;
    localparam logic [2:0] R_CAUSE  = 3'd4;
    localparam logic [2:0] R_VBASE  = 3'd5;
    localparam logic [2:0] R_EOI    = 3'd6;

    logic [1:0]       state;
    logic [N_SRC-1:0] pend, mask, src_q;
    logic             gie;
    logic [31:0]      vbase;
    logic             cause_v;
    logic [4:0]       cause_idx;
    logic [4:0]       idx;
    logic             iack_q;

    logic             sel, wr_en, rd_en, ack, ack_take, eoi, still_valid, win_any;
    logic [2:0]       reg_off;
    logic [N_SRC-1:0] rise, active, w1c, mask_nxt, pend_set, pend_nxt, idx_oh;
    logic             gie_nxt;
    logic [31:0]      vbase_nxt, rd_data;
    logic [4:0]       win_idx;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^cop_addr_i[1:0];

    assign sel     = (cop_addr_i[31:5] == BASE_ADDR[31:5]);
    assign wr_en   = sel && (cop_mem_ctl_i == SW_CODE);
    assign rd_en   = sel && (cop_mem_ctl_i == LW_CODE);
    assign reg_off = cop_addr_i[4:2];
    assign rise    = src_i & ~src_q;
    assign active  = pend & mask;
    assign win_any = |active;
    assign ack     = iack_i & ~iack_q;

    always_comb begin
        mask_nxt  = mask;
        gie_nxt   = gie;
        vbase_nxt = vbase;
        w1c       = '0;
        eoi       = 1'b0;
        if (wr_en) begin
            case (reg_off)
                R_PEND:  w1c       = cop_data_i[N_SRC-1:0];
                R_MASK:  mask_nxt  = cop_data_i[N_SRC-1:0];
                R_CTRL:  gie_nxt   = cop_data_i[0];
                R_VBASE: vbase_nxt = cop_data_i;
                R_EOI:   eoi       = 1'b1;
                default: ;
            endcase
        end
    end

    // A new edge beats a software clear of the same bit; the acknowledge clear beats both.
    assign pend_set = (pend & ~w1c) | rise;
    assign ack_take = (state == S_REQ) && ack;
    assign pend_nxt = ack_take ? (pend_set & ~idx_oh) : pend_set;

    always_comb begin
        win_idx = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (active[i-1]) win_idx = 5'(i - 1);
        end
    end

    always_comb begin
        idx_oh = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            idx_oh[i] = (idx == 5'(i));
        end
    end

    // Withdrawal looks at the values this edge will commit, so a masking write drops irq_o at once.
    assign still_valid = gie_nxt && |(pend_set & mask_nxt & idx_oh);

    always_comb begin
        rd_data = '0;
        case (reg_off)
            R_STATUS: rd_data = 32'(active);
            R_PEND:   rd_data = 32'(pend);
            R_MASK:   rd_data = 32'(mask);
            R_CTRL:   rd_data = {31'd0, gie};
            R_CAUSE:  rd_data = {cause_v, 26'd0, cause_idx};
            R_VBASE:  rd_data = vbase;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            pend       <= '0;
            mask       <= '0;
            src_q      <= '0;
            gie        <= 1'b0;
            vbase      <= '0;
            cause_v    <= 1'b0;
            cause_idx  <= '0;
            idx        <= '0;
            iack_q     <= 1'b0;
            irq_o      <= 1'b0;
            irq_addr_o <= '0;
            cop_dout_o <= '0;
        end else begin
            src_q      <= src_i;
            iack_q     <= iack_i;
            mask       <= mask_nxt;
            gie        <= gie_nxt;
            vbase      <= vbase_nxt;
            pend       <= pend_nxt;
            cop_dout_o <= rd_en ? rd_data : '0;
            case (state)
                S_IDLE: begin
                    if (gie && win_any) begin
                        state      <= S_REQ;
                        idx        <= win_idx;
                        irq_o      <= 1'b1;
                        irq_addr_o <= vbase + {23'd0, win_idx, 4'd0};
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        cause_v   <= 1'b1;
                        cause_idx <= idx;
                        state     <= S_SERVICE;
                        irq_o     <= 1'b0;
                    end else if (!still_valid) begin
                        state <= S_IDLE;
                        irq_o <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (eoi) begin
                        cause_v <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    irq_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/irq_ctl.md
Name: irq_ctl

Overview:
- Programmable interrupt controller that is the responder side of the core's interrupt handshake (irq_i / irq_addr / iack_o).
- Also a memory-mapped slave on the core's coprocessor bus (cop_addr_o / cop_data_o / cop_mem_ctl_o / cop_dout).
- Latches rising edges from N_SRC peripheral sources, masks and prioritises them, and presents one request plus vector address to the core.
- Tracks the in-service source until software writes end-of-interrupt.

Parameters:
N_SRC, 8, number of interrupt sources (1..32)
BASE_ADDR, 32'h0000_1000, register window base; window is 32 bytes, selected on cop_addr_i[31:5]
SW_CODE, 4'd10, cop_mem_ctl_i value meaning word store; must match the store-word code in mips789_defs.v
LW_CODE, 4'd4, cop_mem_ctl_i value meaning word load; must match the load-word code in mips789_defs.v

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
src_i  in  N_SRC  interrupt sources, synchronous to clk, rising-edge sensitive
cop_addr_i  in  32  byte address from core MEM stage
cop_data_i  in  32  store data
cop_mem_ctl_i  in  4  access code
cop_dout_o  out  32  load data to core; ORed with memory data, so 0 when not responding
irq_o  out  1  interrupt request to core irq_i
irq_addr_o  out  32  vector to core irq_addr
iack_i  in  1  acknowledge from core iack_o

Behaviour:
- Reset (rst==0 at a clk edge) clears all state. Resulting values: PEND=0, MASK=0, GIE=0, VBASE=0, state=IDLE, CAUSE=0, src_q=0, iack_q=0, irq_o=0, irq_addr_o=0, cop_dout_o=0.
- Edge detect: src_q <= src_i; on each clk edge, PEND[k] is set when src_i[k] & ~src_q[k].
- Register map (word offsets; sel = cop_addr_i[31:5]==BASE_ADDR[31:5]; byte offset bits [1:0] ignored):
  - 0x00 STATUS, RO: PEND & MASK.
  - 0x04 PEND, RW1C: write 1 clears the bit.
  - 0x08 MASK, RW.
  - 0x0C CTRL, RW: bit0 = GIE.
  - 0x10 CAUSE, RO: bit31 = in-service valid, [4:0] = index.
  - 0x14 VBASE, RW.
  - 0x18 EOI, WO: any write.
  - 0x1C reserved: reads 0, writes ignored.
  - Bits at or above N_SRC read 0 and ignore writes.
- Write when sel && cop_mem_ctl_i==SW_CODE; takes effect at that clk edge. Repeated identical writes (pipeline pause holding the bus) are harmless; every register is idempotent.
- Read when sel && cop_mem_ctl_i==LW_CODE. cop_dout_o is registered, valid exactly one cycle after the access cycle, and 0 in every other cycle.
- Set/clear collision: a new edge on bit k in the same cycle as a W1C of bit k leaves PEND[k]=1.
- Priority: lowest index among PEND & MASK wins; idx is 5 bits.
- Acknowledge edge: iack_q <= iack_i; ack = iack_i & ~iack_q. A multi-cycle iack counts once.
- FSM:
  - IDLE: if GIE && |(PEND&MASK), go to REQ next edge. On that edge, capture idx and load irq_addr_o = VBASE + (idx<<4) (32-bit wrap). irq_o=1 from the first REQ cycle.
  - REQ: irq_o=1 and irq_addr_o held stable.
    - On ack: clear PEND[idx] (the ack clear wins over a same-cycle new edge on idx, which is then lost), set CAUSE={1,…,idx}, go to SERVICE; irq_o=0 from the next cycle.
    - Else if GIE==0 or PEND[idx]&MASK[idx]==0: withdraw (irq_o=0 next cycle), go to IDLE. Ack takes precedence over withdraw in the same cycle.
    - A higher-priority source arriving in REQ does not change idx.
  - SERVICE: irq_o=0; new edges still accumulate in PEND. An EOI write sets CAUSE[31]=0 and goes to IDLE; re-arbitration happens from IDLE on the following edge. An ack in SERVICE is ignored. No nesting.
- A reset mid-operation (any state) returns to IDLE with all outputs 0 at that edge.

Test Plan:
- Reset, then read all registers -> each reads 0 exactly one cycle after the load, with irq_o=0. Read 0x1C -> 0. Access outside the window -> cop_dout_o stays 0.
- Write MASK=0x0A, VBASE=0x8000_0000, GIE=1; pulse src_i[1] and src_i[3] in the same cycle -> PEND=0x0A, irq_o=1, irq_addr_o=0x8000_0010.
- Hold iack_i high for 3 cycles -> PEND=0x08, CAUSE=0x8000_0001, irq_o low for the rest of SERVICE.
- Write EOI -> CAUSE[31]=0. Next request comes up with irq_addr_o=0x8000_0030.
- In REQ for idx 2, write MASK bit2=0 -> irq_o drops the next cycle, state returns to IDLE, PEND[2] stays 1.
- Repeat with the mask write and iack_i in the same cycle -> ack wins, CAUSE=0x8000_0002.
- W1C of PEND bit5 in the same cycle as a rising edge on src_i[5] -> PEND[5]=1. Assert rst=0 during REQ -> irq_o=0 and irq_addr_o=0 the next cycle.
